mod_inv_finalize: RTL and testbench

Downstream stage of `bin_ext_gcd`: it takes the signed Bezout coefficient, the gcd and the original operands, and produces a canonical, self-checked modular inverse. It reduces the coefficient into [0, mod) and proves the result with a bit-serial interleaved modular multiply (arg·inv mod mod == 1). It reports one of four status codes and sits between the gcd engine and the Paillier key/ciphertext datapath.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/mod_inv_finalize_if.sv | 24 ++
 rtl/mod_mul_step.sv | 29 ++
 rtl/mod_inv_finalize.sv | 128 ++++++++++++
 tb/tb_mod_inv_finalize.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd engine and its downstream modular-inverse stage.
package gcd_pkg;

    localparam logic [1:0] ST_OK          = 2'b00;
    localparam logic [1:0] ST_NO_INV      = 2'b01;
    localparam logic [1:0] ST_RANGE       = 2'b10;
    localparam logic [1:0] ST_VERIFY_FAIL = 2'b11;

    // Upstream guarantees |coef| < 4*mod, so four corrections always suffice.
    localparam int MAX_ADJ = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_VERIFY,
        S_DONE
    } state_e;

endpackage

// File: rtl/mod_inv_finalize_if.sv
// Start/operand/result bundle between the gcd engine, mod_inv_finalize and its consumer.
interface mod_inv_finalize_if #(
    parameter int NBITS = 256
);
    logic             start_p;
    logic [NBITS+2:0] coef_in;
    logic [NBITS-1:0] gcd_in;
    logic [NBITS-1:0] arg_in;
    logic [NBITS-1:0] mod_in;
    logic [NBITS-1:0] inv;
    logic [1:0]       status;
    logic             busy;
    logic             done_p;

    modport master (
        output start_p, coef_in, gcd_in, arg_in, mod_in,
        input  inv, status, busy, done_p
    );

    modport slave (
        input  start_p, coef_in, gcd_in, arg_in, mod_in,
        output inv, status, busy, done_p
    );
endinterface

// File: rtl/mod_mul_step.sv
// One MSB-first step of an interleaved modular multiply: p_next = (2p + bit*r) mod mod.
// Callers keep p < mod and r < mod, so each stage needs at most one subtraction.
module mod_mul_step #(
    parameter int NBITS = 256
) (
    input  logic [NBITS:0]   p_i,
    input  logic [NBITS-1:0] r_i,
    input  logic [NBITS-1:0] mod_i,
    input  logic             bit_i,
    output logic [NBITS:0]   p_next_o
);
    logic [NBITS:0]   dbl;
    logic             dbl_ge;
    logic [NBITS:0]   dbl_red;
    logic [NBITS+1:0] sum;
    logic             sum_ge;
    logic [NBITS:0]   sum_red;

    // The doubled value's true MSB is p_i[NBITS]; wrap-around subtraction stays exact.
    assign dbl     = {p_i[NBITS-1:0], 1'b0};
    assign dbl_ge  = p_i[NBITS] || (dbl >= {1'b0, mod_i});
    assign dbl_red = dbl_ge ? (dbl - {1'b0, mod_i}) : dbl;

    assign sum     = {1'b0, dbl_red} + {2'b00, r_i};
    assign sum_ge  = sum >= {2'b00, mod_i};
    assign sum_red = sum_ge ? (sum[NBITS:0] - {1'b0, mod_i}) : sum[NBITS:0];

    assign p_next_o = bit_i ? sum_red : dbl_red;
endmodule

// File: rtl/mod_inv_finalize.sv
// Reduces a signed Bezout coefficient into [0, mod) and proves arg*inv mod mod == 1
// with a bit-serial multiply before publishing it as the canonical inverse.
module mod_inv_finalize
    import gcd_pkg::*;
#(
    parameter int NBITS = 256
) (
    input  logic              clk,
    input  logic              rst,
    mod_inv_finalize_if.slave bus
);
    localparam int             IW        = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IW-1:0]  LAST_BIT  = IW'(NBITS - 1);
    localparam logic [2:0]     ADJ_LIMIT = 3'(MAX_ADJ);

    state_e                  state_q;
    logic signed [NBITS+2:0] r_q;
    logic [NBITS-1:0]        arg_q;
    logic [NBITS-1:0]        mod_q;
    logic [NBITS:0]          p_q;
    logic [NBITS:0]          p_d;
    logic [IW-1:0]           bit_q;
    logic [2:0]              adj_q;
    logic [NBITS-1:0]        inv_q;
    logic [1:0]              status_q;
    logic                    busy_q;
    logic                    done_q;

    logic signed [NBITS+2:0] mod_ext;
    logic                    r_neg;
    logic                    r_ge;
    logic                    no_inv;

    assign mod_ext = {3'b000, mod_q};
    assign r_neg   = r_q[NBITS+2];
    assign r_ge    = !r_neg && (r_q >= mod_ext);
    assign no_inv  = (bus.mod_in < NBITS'(2)) || (bus.gcd_in != NBITS'(1));

    mod_mul_step #(
        .NBITS (NBITS)
    ) u_step (
        .p_i      (p_q),
        .r_i      (r_q[NBITS-1:0]),
        .mod_i    (mod_q),
        .bit_i    (arg_q[bit_q]),
        .p_next_o (p_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            arg_q    <= '0;
            mod_q    <= '0;
            p_q      <= '0;
            bit_q    <= '0;
            adj_q    <= '0;
            inv_q    <= '0;
            status_q <= ST_OK;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_p) begin
                        r_q   <= bus.coef_in;
                        arg_q <= bus.arg_in;
                        mod_q <= bus.mod_in;
                        adj_q <= '0;
                        if (no_inv) begin
                            status_q <= ST_NO_INV;
                            inv_q    <= '0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    if (r_neg || r_ge) begin
                        // A fifth correction means the upstream contract was broken.
                        if (adj_q == ADJ_LIMIT) begin
                            status_q <= ST_RANGE;
                            inv_q    <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            r_q   <= r_neg ? (r_q + mod_ext) : (r_q - mod_ext);
                            adj_q <= adj_q + 3'd1;
                        end
                    end else begin
                        p_q     <= '0;
                        bit_q   <= LAST_BIT;
                        state_q <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    p_q <= p_d;
                    if (bit_q == '0) begin
                        if (p_d == (NBITS+1)'(1)) begin
                            status_q <= ST_OK;
                            inv_q    <= r_q[NBITS-1:0];
                        end else begin
                            status_q <= ST_VERIFY_FAIL;
                            inv_q    <= '0;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        bit_q <= bit_q - IW'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.inv    = inv_q;
    assign bus.status = status_q;
    assign bus.busy   = busy_q;
    assign bus.done_p = done_q;
endmodule

// File: tb/tb_mod_inv_finalize.sv
// Directed bench for mod_inv_finalize: a 256-bit instance for the named cases and a
// 10-bit instance swept over every arg modulo 961 against brute-force inverses.
module tb_mod_inv_finalize;

    logic clk;
    logic rst;
    int   checkCount = 0;
    int   failCount  = 0;

    mod_inv_finalize_if #(.NBITS(256)) bus ();
    mod_inv_finalize_if #(.NBITS(10))  sbus ();

    mod_inv_finalize #(.NBITS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mod_inv_finalize #(.NBITS(10)) sdut (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [259:0] observed,
                               input logic [259:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [258:0] coef, input logic [255:0] gcdV,
                                 input logic [255:0] argV, input logic [255:0] modV);
        bus.coef_in = coef;
        bus.gcd_in  = gcdV;
        bus.arg_in  = argV;
        bus.mod_in  = modV;
        bus.start_p = 1'b1;
    endtask

    // Edge E0 counts as 1; pokeAt > 0 fires a junk start while the DUT is busy.
    task automatic waitDone(input int pokeAt, output int lat);
        lat = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.start_p = 1'b0;
            if (pokeAt > 0 && c == pokeAt) begin
                bus.start_p = 1'b1;
                bus.coef_in = 259'(90);
                bus.gcd_in  = 256'(3);
            end
            if (pokeAt > 0 && c == pokeAt + 1) bus.start_p = 1'b0;
            if (c == 2 && !bus.done_p) checkOutput("busyAfterE0", 260'(bus.busy), 260'(1));
            if (bus.done_p) begin
                lat = c;
                break;
            end
        end
        bus.start_p = 1'b0;
    endtask

    task automatic runCase(input string tag, input logic [258:0] coef, input logic [255:0] gcdV,
                           input logic [255:0] argV, input logic [255:0] modV,
                           input logic [1:0] expStatus, input logic [255:0] expInv,
                           input int expLat, input int pokeAt);
        int lat;
        applyStimulus(coef, gcdV, argV, modV);
        waitDone(pokeAt, lat);
        checkOutput({tag, ".lat"},    260'(lat),        260'(expLat));
        checkOutput({tag, ".status"}, 260'(bus.status), 260'(expStatus));
        checkOutput({tag, ".inv"},    260'(bus.inv),    260'(expInv));
        checkOutput({tag, ".busy"},   260'(bus.busy),   260'(0));
        @(posedge clk);
        #1;
        checkOutput({tag, ".holdStatus"}, 260'(bus.status), 260'(expStatus));
        checkOutput({tag, ".holdInv"},    260'(bus.inv),    260'(expInv));
    endtask

    function automatic int gcdOf(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    initial begin
        int lat;
        int doneSeen;
        int g, x, j, coef, expLat;

        rst = 1'b1;
        bus.start_p = 1'b0;
        bus.coef_in = '0;
        bus.gcd_in  = '0;
        bus.arg_in  = '0;
        bus.mod_in  = '0;
        sbus.start_p = 1'b0;
        sbus.coef_in = '0;
        sbus.gcd_in  = '0;
        sbus.arg_in  = '0;
        sbus.mod_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.inv",    260'(bus.inv),    260'(0));
        checkOutput("reset.status", 260'(bus.status), 260'(0));
        checkOutput("reset.busy",   260'(bus.busy),   260'(0));
        checkOutput("reset.done",   260'(bus.done_p), 260'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 319 mod 177 = 142 and 142*91 = 12922 = 73*177 + 1
        runCase("k0",     259'(91),    256'(1), 256'(319), 256'(177), 2'b00, 256'(91), 258, 0);
        runCase("k1",     259'(-86),   256'(1), 256'(319), 256'(177), 2'b00, 256'(91), 259, 0);
        runCase("k2",     259'(445),   256'(1), 256'(319), 256'(177), 2'b00, 256'(91), 260, 0);
        runCase("k4pos",  259'(799),   256'(1), 256'(319), 256'(177), 2'b00, 256'(91), 262, 0);
        runCase("k4neg",  259'(-617),  256'(1), 256'(319), 256'(177), 2'b00, 256'(91), 262, 0);
        runCase("noInv",  259'(1),     256'(3), 256'(6),   256'(9),   2'b01, 256'(0),  1,   0);
        runCase("mod1",   259'(0),     256'(1), 256'(6),   256'(1),   2'b01, 256'(0),  1,   0);
        runCase("rangeN", 259'(-1000), 256'(1), 256'(319), 256'(177), 2'b10, 256'(0),  6,   0);
        runCase("rangeP", 259'(976),   256'(1), 256'(319), 256'(177), 2'b10, 256'(0),  6,   0);
        runCase("vfail",  259'(90),    256'(1), 256'(319), 256'(177), 2'b11, 256'(0),  258, 0);
        runCase("poke",   259'(91),    256'(1), 256'(319), 256'(177), 2'b00, 256'(91), 258, 50);

        // Start in the DONE cycle is dropped; the one in the following cycle is taken.
        applyStimulus(259'(445), 256'(1), 256'(319), 256'(177));
        waitDone(0, lat);
        checkOutput("b2bA.lat", 260'(lat), 260'(260));
        checkOutput("b2bA.inv", 260'(bus.inv), 260'(91));
        applyStimulus(259'(5), 256'(3), 256'(6), 256'(9));
        @(posedge clk);
        #1;
        checkOutput("doneStart.status", 260'(bus.status), 260'(0));
        checkOutput("doneStart.done",   260'(bus.done_p), 260'(0));
        checkOutput("doneStart.busy",   260'(bus.busy),   260'(0));
        applyStimulus(259'(-86), 256'(1), 256'(319), 256'(177));
        waitDone(0, lat);
        checkOutput("b2bB.lat",    260'(lat),        260'(259));
        checkOutput("b2bB.status", 260'(bus.status), 260'(0));
        checkOutput("b2bB.inv",    260'(bus.inv),    260'(91));
        @(posedge clk);
        #1;

        applyStimulus(259'(91), 256'(1), 256'(319), 256'(177));
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.start_p = 1'b0;
        end
        checkOutput("midVerify.busy", 260'(bus.busy), 260'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstMid.inv",    260'(bus.inv),    260'(0));
        checkOutput("rstMid.status", 260'(bus.status), 260'(0));
        checkOutput("rstMid.busy",   260'(bus.busy),   260'(0));
        checkOutput("rstMid.done",   260'(bus.done_p), 260'(0));
        rst = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_p) doneSeen++;
        end
        checkOutput("rstMid.noDone", 260'(doneSeen), 260'(0));

        // Coefficients are offset by -2..2 multiples of the modulus to exercise REDUCE.
        for (int a = 1; a <= 960; a++) begin
            g = gcdOf(a, 961);
            x = 0;
            if (g == 1) begin
                for (int t = 1; t < 961; t++) begin
                    if ((t * a) % 961 == 1) begin
                        x = t;
                        break;
                    end
                end
            end
            j = (a % 5) - 2;
            coef = (g == 1) ? (x + j * 961) : 0;
            expLat = (g == 1) ? (((j < 0) ? -j : j) + 12) : 1;
            sbus.coef_in = 13'(coef);
            sbus.gcd_in  = 10'(g);
            sbus.arg_in  = 10'(a);
            sbus.mod_in  = 10'(961);
            sbus.start_p = 1'b1;
            lat = 0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk);
                #1;
                if (c == 1) sbus.start_p = 1'b0;
                if (sbus.done_p) begin
                    lat = c;
                    break;
                end
            end
            sbus.start_p = 1'b0;
            checkOutput($sformatf("sweep%0d.lat", a),    260'(lat),         260'(expLat));
            checkOutput($sformatf("sweep%0d.status", a), 260'(sbus.status), (g == 1) ? 260'(0) : 260'(1));
            checkOutput($sformatf("sweep%0d.inv", a),    260'(sbus.inv),    260'(x));
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
